// File: rtl/rq_dmaw_dwr_tlp_gen_pkg.sv
// Shared definitions for the RQ DMA-write TLP generator: descriptor layout,
// request type, MPS decode and FSM state encoding.
package rq_dmaw_dwr_tlp_gen_pkg;

  localparam int unsigned DescAddrLsb    = 2;
  localparam int unsigned DescDwCntLsb   = 64;
  localparam int unsigned DescReqTypeLsb = 75;
  localparam int unsigned DescReqIdLsb   = 80;
  localparam int unsigned DescTagLsb     = 96;

  localparam logic [3:0] ReqTypeMemWr = 4'b0001;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StData,
    StDone
  } state_e;

  function automatic logic [10:0] mps_bytes(input logic [1:0] code);
    logic [10:0] bytes;
    case (code)
      2'd0:    bytes = 11'd128;
      2'd1:    bytes = 11'd256;
      2'd2:    bytes = 11'd512;
      default: bytes = 11'd1024;
    endcase
    return bytes;
  endfunction

endpackage

// File: rtl/rq_chunk_calc.sv
// Size of the next TLP: the remaining length clipped to the end of the current
// MPS-aligned window, plus the address/remaining length after that TLP.
module rq_chunk_calc #(
  parameter int unsigned LEN_W = 32
) (
  input  logic [63:0]      addr,
  input  logic [LEN_W-1:0] rem,
  input  logic [10:0]      mps,
  output logic [10:0]      chunk,
  output logic [63:0]      next_addr,
  output logic [LEN_W-1:0] next_rem
);

  logic [10:0] room;

  // mps is a power of two, so the window offset is a simple mask.
  assign room      = mps - (addr[10:0] & (mps - 11'd1));
  assign chunk     = (rem < LEN_W'(room)) ? rem[10:0] : room;
  assign next_addr = addr + 64'(chunk);
  assign next_rem  = rem - LEN_W'(chunk);

endmodule

// File: rtl/rq_dmaw_dwr_tlp_gen.sv
// Splits DMA-write commands into MemWr TLPs: one descriptor beat followed by
// pass-through payload beats per TLP, each TLP confined to one MPS window.
module rq_dmaw_dwr_tlp_gen
  import rq_dmaw_dwr_tlp_gen_pkg::*;
#(
  parameter int unsigned DATA_W   = 512,
  parameter int unsigned LEN_W    = 32,
  parameter logic [7:0]  TAG_INIT = 8'h00
) (
  input  logic              user_clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [63:0]       cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              rq_dmaw_dwr_axis_tvalid,
  output logic [DATA_W-1:0] rq_dmaw_dwr_axis_tdata,
  output logic              rq_dmaw_dwr_axis_tlast,
  input  logic              rq_dmaw_dwr_axis_tready,
  input  logic [1:0]        cfg_max_payload,
  input  logic [15:0]       cfg_requester_id,
  output logic              cmd_done,
  output logic              err_len,
  output logic [31:0]       tlp_cnt
);

  state_e           state_q, state_d;
  logic [63:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [10:0]      mps_q, mps_d;
  logic [4:0]       beat_cnt_q, beat_cnt_d;
  logic [7:0]       tag_q, tag_d;
  logic [31:0]      tlp_cnt_q, tlp_cnt_d;
  logic             err_q, err_d;

  logic [10:0]       chunk;
  logic [63:0]       next_addr;
  logic [LEN_W-1:0]  next_rem;
  logic [DATA_W-1:0] desc;
  logic              last_tlp_beat;
  logic              unused_addr;

  assign unused_addr = ^cmd_addr[5:0];

  rq_chunk_calc #(
    .LEN_W(LEN_W)
  ) u_chunk_calc (
    .addr     (addr_q),
    .rem      (rem_q),
    .mps      (mps_q),
    .chunk    (chunk),
    .next_addr(next_addr),
    .next_rem (next_rem)
  );

  always_comb begin
    desc = '0;
    desc[63:DescAddrLsb]          = addr_q[63:2];
    desc[DescDwCntLsb +: 11]      = {2'b00, chunk[10:2]};
    desc[DescReqTypeLsb +: 4]     = ReqTypeMemWr;
    desc[DescReqIdLsb +: 16]      = cfg_requester_id;
    desc[DescTagLsb +: 8]         = tag_q;
  end

  assign last_tlp_beat = (beat_cnt_q == 5'd1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    mps_d      = mps_q;
    beat_cnt_d = beat_cnt_q;
    tag_d      = tag_q;
    tlp_cnt_d  = tlp_cnt_q;
    err_d      = err_q;

    cmd_ready               = 1'b0;
    s_axis_tready           = 1'b0;
    rq_dmaw_dwr_axis_tvalid = 1'b0;
    rq_dmaw_dwr_axis_tdata  = '0;
    rq_dmaw_dwr_axis_tlast  = 1'b0;
    cmd_done                = 1'b0;

    case (state_q)
      StIdle: begin
        // Held low while reset is asserted so no command is seen as accepted.
        cmd_ready = ~reset;
        if (cmd_valid) begin
          addr_d = {cmd_addr[63:6], 6'b0};
          rem_d  = cmd_len & ~LEN_W'(63);
          mps_d  = mps_bytes(cfg_max_payload);
          if (cmd_len[5:0] != 6'd0) begin
            err_d = 1'b1;
          end
          state_d = (rem_d == '0) ? StDone : StHdr;
        end
      end
      StHdr: begin
        rq_dmaw_dwr_axis_tvalid = 1'b1;
        rq_dmaw_dwr_axis_tdata  = desc;
        if (rq_dmaw_dwr_axis_tready) begin
          beat_cnt_d = chunk[10:6];
          tag_d      = tag_q + 8'd1;
          tlp_cnt_d  = tlp_cnt_q + 32'd1;
          state_d    = StData;
        end
      end
      StData: begin
        rq_dmaw_dwr_axis_tvalid = s_axis_tvalid;
        rq_dmaw_dwr_axis_tdata  = s_axis_tdata;
        rq_dmaw_dwr_axis_tlast  = last_tlp_beat;
        s_axis_tready           = rq_dmaw_dwr_axis_tready;
        if (s_axis_tvalid && rq_dmaw_dwr_axis_tready) begin
          beat_cnt_d = beat_cnt_q - 5'd1;
          // Framing follows cmd_len; a disagreeing tlast is only flagged.
          if (s_axis_tlast != (last_tlp_beat && (rem_q == LEN_W'(chunk)))) begin
            err_d = 1'b1;
          end
          if (last_tlp_beat) begin
            addr_d  = next_addr;
            rem_d   = next_rem;
            state_d = (next_rem == '0) ? StDone : StHdr;
          end
        end
      end
      StDone: begin
        cmd_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rem_q      <= '0;
      mps_q      <= 11'd128;
      beat_cnt_q <= '0;
      tag_q      <= TAG_INIT;
      tlp_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      mps_q      <= mps_d;
      beat_cnt_q <= beat_cnt_d;
      tag_q      <= tag_d;
      tlp_cnt_q  <= tlp_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_len = err_q;
  assign tlp_cnt = tlp_cnt_q;

endmodule

// File: tb/tb_rq_dmaw_dwr_tlp_gen.sv
// Directed bench for rq_dmaw_dwr_tlp_gen: table of commands with hand-computed
// TLP splits, plus zero/odd length, early tlast, reset mid-TLP and backpressure.
module tb_rq_dmaw_dwr_tlp_gen;

  localparam logic [15:0] REQ_ID = 16'hBEEF;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [63:0]  cmd_addr;
  logic [31:0]  cmd_len;
  logic         s_tvalid;
  logic [511:0] s_tdata;
  logic         s_tlast;
  logic         s_tready;
  logic         rq_tvalid;
  logic [511:0] rq_tdata;
  logic         rq_tlast;
  logic         rq_tready;
  logic [1:0]   cfg_mps;
  logic         cmd_done;
  logic         err_len;
  logic [31:0]  tlp_cnt;

  always #5 clk = ~clk;

  rq_dmaw_dwr_tlp_gen dut (
    .user_clk               (clk),
    .reset                  (rst),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_addr               (cmd_addr),
    .cmd_len                (cmd_len),
    .s_axis_tvalid          (s_tvalid),
    .s_axis_tdata           (s_tdata),
    .s_axis_tlast           (s_tlast),
    .s_axis_tready          (s_tready),
    .rq_dmaw_dwr_axis_tvalid(rq_tvalid),
    .rq_dmaw_dwr_axis_tdata (rq_tdata),
    .rq_dmaw_dwr_axis_tlast (rq_tlast),
    .rq_dmaw_dwr_axis_tready(rq_tready),
    .cfg_max_payload        (cfg_mps),
    .cfg_requester_id       (REQ_ID),
    .cmd_done               (cmd_done),
    .err_len                (err_len),
    .tlp_cnt                (tlp_cnt)
  );

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
    logic [1:0]  mps;
    int          ntlp;
    logic        err;
  } cmd_vec_t;

  typedef struct {
    logic [63:0] addr;
    int          dw;
  } tlp_vec_t;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  exp_tag = 8'h00;
  logic [31:0] exp_tlps = 0;
  logic        exp_err = 1'b0;
  tlp_vec_t    exp_q[$];
  cmd_vec_t    cmd_tab[6];
  tlp_vec_t    tlp_tab[10];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] pay(input logic [31:0] salt, input int i);
    return {16{salt ^ 32'(i)}};
  endfunction

  // Runs one command to completion against the TLPs queued in exp_q.
  task automatic run_cmd(input logic [63:0] a, input logic [31:0] len, input logic [1:0] mps,
                         input bit bp, input int tlast_beat);
    int total = 0, tidx = 0, didx = 0, pidx = 0, left = 0, cyc = 0, tl;
    int acc_cyc = -1, last_cyc = -1, done_cyc = -1, first_hdr = -1;
    bit hdr = 1'b1, stalled = 1'b0;
    logic [511:0] exp_d;
    foreach (exp_q[k]) total += exp_q[k].dw / 16;
    tl = (tlast_beat < 0) ? total - 1 : tlast_beat;
    while (done_cyc < 0 && cyc < 4000) begin
      @(negedge clk);
      cmd_valid = (acc_cyc < 0);
      cmd_addr  = a;
      cmd_len   = len;
      cfg_mps   = mps;
      rq_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tvalid  = (pidx < total) && (!bp || $urandom_range(0, 3) != 0);
      s_tdata   = pay(a[31:0], pidx);
      s_tlast   = (pidx == tl);
      #1;
      if (acc_cyc < 0 && cmd_ready) acc_cyc = cyc;
      if (cmd_done) done_cyc = cyc;
      if (hdr && stalled) check("hdr_hold_valid", rq_tvalid, 1);
      if (rq_tvalid) begin
        if (hdr) begin
          check("hdr_s_tready", s_tready, 0);
          if (tidx >= exp_q.size()) begin
            check("tlp_count", tidx + 1, exp_q.size());
          end else begin
            exp_d = '0;
            exp_d[63:0]    = exp_q[tidx].addr;
            exp_d[74:64]   = 11'(exp_q[tidx].dw);
            exp_d[78:75]   = 4'b0001;
            exp_d[95:80]   = REQ_ID;
            exp_d[103:96]  = exp_tag;
            check("descriptor", rq_tdata, exp_d);
            check("hdr_tlast", rq_tlast, 0);
            if (first_hdr < 0) first_hdr = cyc;
            if (rq_tready) begin
              hdr     = 1'b0;
              stalled = 1'b0;
              left    = exp_q[tidx].dw / 16;
              exp_tag++;
              exp_tlps++;
            end else begin
              stalled = 1'b1;
            end
          end
        end else begin
          check("payload", rq_tdata, pay(a[31:0], didx));
          check("data_tlast", rq_tlast, left == 1);
          if (rq_tready) begin
            didx++;
            left--;
            last_cyc = cyc;
            if (left == 0) begin
              hdr = 1'b1;
              tidx++;
            end
          end
        end
      end
      if (s_tvalid && s_tready) pidx++;
      cyc++;
    end
    check("cmd_done_seen", done_cyc >= 0, 1);
    check("tlps_emitted", tidx, exp_q.size());
    check("beats_emitted", didx, total);
    check("cmd_done_latency", done_cyc, ((total == 0) ? acc_cyc : last_cyc) + 1);
    if (total > 0) check("hdr_latency", first_hdr, acc_cyc + 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    s_tvalid  = 1'b0;
    #1;
    check("cmd_done_pulse", cmd_done, 0);
    check("cmd_ready_after", cmd_ready, 1);
    check("tlp_cnt", tlp_cnt, exp_tlps);
    check("err_len", err_len, exp_err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_tvalid"}, rq_tvalid, 0);
    check({tag, "_tdata"}, rq_tdata, 0);
    check({tag, "_tlast"}, rq_tlast, 0);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_cmd_done"}, cmd_done, 0);
    check({tag, "_err_len"}, err_len, 0);
    check({tag, "_tlp_cnt"}, tlp_cnt, 0);
  endtask

  initial begin
    int tp;
    cmd_tab[0] = '{64'h1000, 32'd64,   2'd1, 1, 1'b0};
    cmd_tab[1] = '{64'h10C0, 32'd512,  2'd1, 3, 1'b0};
    cmd_tab[2] = '{64'h3F80, 32'd2048, 2'd3, 3, 1'b0};
    cmd_tab[3] = '{64'h5000, 32'd256,  2'd2, 1, 1'b0};
    cmd_tab[4] = '{64'h6010, 32'd128,  2'd0, 1, 1'b0};
    cmd_tab[5] = '{64'h7000, 32'd100,  2'd0, 1, 1'b1};
    tlp_tab[0] = '{64'h1000, 16};
    tlp_tab[1] = '{64'h10C0, 16};
    tlp_tab[2] = '{64'h1100, 64};
    tlp_tab[3] = '{64'h1200, 48};
    tlp_tab[4] = '{64'h3F80, 32};
    tlp_tab[5] = '{64'h4000, 256};
    tlp_tab[6] = '{64'h4400, 224};
    tlp_tab[7] = '{64'h5000, 64};
    tlp_tab[8] = '{64'h6000, 32};
    tlp_tab[9] = '{64'h7000, 16};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tlast = 1'b0;
    rq_tready = 1'b0;
    cfg_mps = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", cmd_ready, 1);

    tp = 0;
    for (int i = 0; i < 6; i++) begin
      exp_q.delete();
      for (int j = 0; j < cmd_tab[i].ntlp; j++) exp_q.push_back(tlp_tab[tp + j]);
      tp += cmd_tab[i].ntlp;
      if (cmd_tab[i].err) exp_err = 1'b1;
      run_cmd(cmd_tab[i].addr, cmd_tab[i].len, cmd_tab[i].mps, 1'b0, -1);
    end

    // Zero length: done at T+1 with no TLP.
    exp_q.delete();
    run_cmd(64'hA000, 32'd0, 2'd1, 1'b0, -1);

    // Reset while the second payload beat of a 4-beat TLP is on the bus.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 64'h8000; cmd_len = 32'd256; cfg_mps = 2'd1;
    rq_tready = 1'b1; s_tvalid = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("rst_seq_hdr", rq_tvalid, 1);
    @(negedge clk);
    s_tvalid = 1'b1; s_tdata = pay(32'h8000, 0); s_tlast = 1'b0;
    #1;
    check("rst_seq_beat1", s_tready, 1);
    @(negedge clk);
    s_tdata = pay(32'h8000, 1);
    #1;
    check("rst_seq_beat2", rq_tvalid, 1);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    s_tvalid = 1'b0;
    exp_tag = 8'h00;
    exp_tlps = 0;
    exp_err = 1'b0;
    exp_q.delete();
    exp_q.push_back('{64'h9000, 16});
    run_cmd(64'h9000, 32'd64, 2'd1, 1'b0, -1);

    // tlast on beat 2 of 4: flagged, framing still 4 beats.
    exp_q.delete();
    exp_q.push_back('{64'hC000, 64});
    exp_err = 1'b1;
    run_cmd(64'hC000, 32'd256, 2'd1, 1'b0, 1);

    // 1024B at MPS=128 under random backpressure on both sides.
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back('{64'hD000 + 64'(128 * i), 32});
    run_cmd(64'hD000, 32'd1024, 2'd0, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
